// File: rtl/alu_sweep_sequencer.sv
// Operand-issue stage for the combinational ALU: accepts one operand pair,
// sweeps every opcode across it, and streams each captured result out with a
// valid/ready handshake while folding results into a rotate-XOR signature.
module alu_sweep_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OPS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [31:0]      alu_select,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_select,
  output logic [WIDTH-1:0] out_result,
  output logic             out_last,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      sweep_count
);

  localparam int unsigned OpW = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1;
  localparam logic [OpW-1:0] LastOp = OpW'(NUM_OPS - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e           state_q, state_d;
  logic [OpW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [OpW-1:0]   out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             capture;

  // Next-state: accept in idle, capture one opcode per unstalled sweep cycle
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    out_res_d   = out_res_q;
    sig_d       = sig_q;
    cnt_d       = cnt_q;

    // A capture only happens when the output slot is free or being drained.
    capture = (state_q == StSweep) && (!out_valid_q || out_ready);

    // Drain without refill empties the slot; a capture below overrides this.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = '0;
          sig_d   = '0;
          state_d = StSweep;
        end
      end
      StSweep: begin
        if (capture) begin
          out_res_d   = alu_result;
          out_sel_d   = op_q;
          out_valid_d = 1'b1;
          out_last_d  = (op_q == LastOp);
          sig_d       = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ alu_result;
          if (op_q == LastOp) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = StIdle;
          end else begin
            op_d = op_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      out_res_q   <= '0;
      sig_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      out_res_q   <= out_res_d;
      sig_q       <= sig_d;
      cnt_q       <= cnt_d;
    end
  end

  // Output mapping; opcodes are zero-extended onto the 32-bit select buses
  always_comb begin
    in_ready    = (state_q == StIdle);
    alu_a       = a_q;
    alu_b       = b_q;
    alu_select  = 32'(op_q);
    out_valid   = out_valid_q;
    out_select  = 32'(out_sel_q);
    out_result  = out_res_q;
    out_last    = out_last_q;
    signature   = sig_q;
    sweep_count = cnt_q;
  end

endmodule
